// File: rtl/rf_write_arbiter.sv
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Shares the register-file write port between the WB stage (A)
//                and a multi-cycle unit (B); fixed A priority plus B
//                starvation guard, registered write outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [4:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [4:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [4:0]        Write_Register,
    output logic [DATA_W-1:0] Write_data,
    output logic              b_forced
);

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                regwrite_q, regwrite_d;
    logic [4:0]          wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q,  wr_data_d;

    logic                w_a_xfer;
    logic                w_b_xfer;
    logic                w_b_lost;

    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        state_d    = state_q;
        wait_cnt_d = 4'd0;
        regwrite_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (!reset) begin
            if (state_q == PRI_A) begin
                a_ready = a_valid;
                b_ready = b_valid && !a_valid;
            end else begin
                b_ready = b_valid;
                a_ready = a_valid && !b_valid;
            end
        end

        w_a_xfer = a_valid && a_ready;
        w_b_xfer = b_valid && b_ready;
        w_b_lost = b_valid && !b_ready;

        if (w_b_lost) begin
            wait_cnt_d = (wait_cnt_q == C_LIMIT) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end

        // Forced priority once B has already lost STARVE_LIMIT cycles and loses again.
        case (state_q)
            PRI_A: if (w_b_lost && wait_cnt_q == C_LIMIT) state_d = PRI_B;
            PRI_B: if (w_b_xfer || !b_valid)              state_d = PRI_A;
            default:                                      state_d = PRI_A;
        endcase

        if (w_a_xfer) begin
            regwrite_d = (a_addr != 5'd0);
            wr_addr_d  = a_addr;
            wr_data_d  = a_data;
        end else if (w_b_xfer) begin
            regwrite_d = (b_addr != 5'd0);
            wr_addr_d  = b_addr;
            wr_data_d  = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PRI_A;
            wait_cnt_q <= 4'd0;
            regwrite_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            regwrite_q <= regwrite_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign RegWrite       = regwrite_q;
    assign Write_Register = wr_addr_q;
    assign Write_data     = wr_data_q;
    assign b_forced       = (state_q == PRI_B);

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Directed vector table plus contention/reset sequences for
//                rf_write_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid;
    logic [4:0]        a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready;
    logic              RegWrite;
    logic [4:0]        Write_Register;
    logic [DATA_W-1:0] Write_data;
    logic              b_forced;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .RegWrite       (RegWrite),
        .Write_Register (Write_Register),
        .Write_data     (Write_data),
        .b_forced       (b_forced)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        e_ar;
        logic        e_br;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Entered at posedge+1; returns at posedge+3 of the cycle where B is force-granted.
    task automatic contend_to_b_grant(input string tag);
        a_valid = 1'b1; a_addr = 5'd1;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBEEF;
        for (int c = 0; c < 5; c++) begin
            a_data = 32'hA0 + 32'(c);
            #2;
            chk({tag, " a_ready"},  {31'd0, a_ready},  32'd1);
            chk({tag, " b_ready"},  {31'd0, b_ready},  32'd0);
            chk({tag, " b_forced"}, {31'd0, b_forced}, 32'd0);
            @(posedge clk); #1;
            chk({tag, " A RegWrite"}, {31'd0, RegWrite}, 32'd1);
            chk({tag, " A data"},     Write_data,        32'hA0 + 32'(c));
        end
        #2;
        chk({tag, " grant b_ready"},  {31'd0, b_ready},  32'd1);
        chk({tag, " grant a_ready"},  {31'd0, a_ready},  32'd0);
        chk({tag, " grant b_forced"}, {31'd0, b_forced}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'h1234};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd5,  32'h1234};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'hCAFE,      1'b0, 1'b1, 1'b1, 5'd9,  32'hCAFE};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd3, 32'h2,         1'b1, 1'b0, 1'b1, 5'd3,  32'h1};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h2,         1'b0, 1'b1, 1'b1, 5'd3,  32'h2};
        vecs[6] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd0,  32'h55};
        vecs[7] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd31, 32'hDEADBEEF};

        reset = 1'b1;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h22;
        @(posedge clk); #1;
        chk("rst a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst b_ready", {31'd0, b_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst RegWrite",       {31'd0, RegWrite},       32'd0);
        chk("rst Write_Register", {27'd0, Write_Register}, 32'd0);
        chk("rst Write_data",     Write_data,              32'd0);
        chk("rst b_forced",       {31'd0, b_forced},       32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            #2;
            chk($sformatf("vec%0d a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].e_ar});
            chk($sformatf("vec%0d b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].e_br});
            @(posedge clk); #1;
            chk($sformatf("vec%0d RegWrite", i),       {31'd0, RegWrite},       {31'd0, vecs[i].e_we});
            chk($sformatf("vec%0d Write_Register", i), {27'd0, Write_Register}, {27'd0, vecs[i].e_wr});
            chk($sformatf("vec%0d Write_data", i),     Write_data,              vecs[i].e_wd);
        end

        // Starvation: B forced on the sixth contended cycle, A resumes right after.
        contend_to_b_grant("starve");
        @(posedge clk); #1;
        chk("starve B RegWrite", {31'd0, RegWrite},       32'd1);
        chk("starve B addr",     {27'd0, Write_Register}, 32'd7);
        chk("starve B data",     Write_data,              32'hBEEF);
        b_valid = 1'b0;
        #2;
        chk("starve A again", {31'd0, a_ready},  32'd1);
        chk("starve unforce", {31'd0, b_forced}, 32'd0);
        @(posedge clk); #1;

        // Reset landing on the forced-B grant cycle drops that write.
        contend_to_b_grant("mid1");
        reset = 1'b1;
        #1;
        chk("midrst b_ready", {31'd0, b_ready}, 32'd0);
        chk("midrst a_ready", {31'd0, a_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst RegWrite",   {31'd0, RegWrite},       32'd0);
        chk("midrst b_forced",   {31'd0, b_forced},       32'd0);
        chk("midrst Write_Reg",  {27'd0, Write_Register}, 32'd0);
        chk("midrst Write_data", Write_data,              32'd0);
        contend_to_b_grant("mid2");
        @(posedge clk); #1;
        chk("mid2 B addr", {27'd0, Write_Register}, 32'd7);
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle RegWrite", {31'd0, RegWrite}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
